// File: rtl/alu_pkg.sv
// Shared types and decode helpers for the sequential ALU.
package alu_pkg;

   // Codes 0-10 are the base RV32I ops, 11-18 the RV32M ops; 19-31 are unused.
   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_PASS_B = 5'd10,
      OP_MUL    = 5'd11,
      OP_MULH   = 5'd12,
      OP_MULHSU = 5'd13,
      OP_MULHU  = 5'd14,
      OP_DIV    = 5'd15,
      OP_DIVU   = 5'd16,
      OP_REM    = 5'd17,
      OP_REMU   = 5'd18
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic is_mul(input logic [4:0] op);
      return (op >= 5'd11) && (op <= 5'd14);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op >= 5'd15) && (op <= 5'd18);
   endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative multiply/divide datapath: one bit per edge on operand magnitudes,
// followed by a sign-correction edge during which done_o is high.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  alu_op_e         op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] res_o,
   output logic            dbz_o
);

   localparam int CNT_W = SHW + 1;

   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2*XLEN-1:0] prod_q;   // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
   logic [XLEN-1:0]  opd_q;     // multiplicand or divisor magnitude
   alu_op_e          op_q;
   logic             div_q;
   logic             neg_q;     // product / quotient sign
   logic             rneg_q;    // remainder sign
   logic             dbz_q;

   logic             sa, sb, a_neg, b_neg;
   logic [XLEN-1:0]  a_mag, b_mag;
   logic [XLEN:0]    sum, shifted, diff;
   logic             ge;
   logic [XLEN-1:0]  new_hi, quot, rem, qfix, rfix;
   logic [2*XLEN-1:0] mul_nxt, div_nxt, pfix;

   // Operand signedness and magnitudes at start
   always_comb begin
      sa    = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
              (op_i == OP_DIV) || (op_i == OP_REM);
      sb    = (op_i == OP_MUL) || (op_i == OP_MULH) ||
              (op_i == OP_DIV) || (op_i == OP_REM);
      a_neg = sa && a_i[XLEN-1];
      b_neg = sb && b_i[XLEN-1];
      a_mag = a_neg ? -a_i : a_i;
      b_mag = b_neg ? -b_i : b_i;
   end

   // One shift-add step and one restoring-division step
   always_comb begin
      sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opd_q} : '0);
      mul_nxt = {sum, prod_q[XLEN-1:1]};
      shifted = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
      ge      = shifted >= {1'b0, opd_q};
      diff    = shifted - {1'b0, opd_q};
      new_hi  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      div_nxt = {new_hi, prod_q[XLEN-2:0], ge};
   end

   // Sign correction and result selection, consumed on the done edge
   always_comb begin
      pfix = neg_q ? -prod_q : prod_q;
      quot = prod_q[XLEN-1:0];
      rem  = prod_q[2*XLEN-1:XLEN];
      // Division by zero leaves |A| as remainder, so sign fix restores A;
      // the quotient is forced to all ones regardless of operand signs.
      qfix = dbz_q ? '1 : (neg_q ? -quot : quot);
      rfix = rneg_q ? -rem : rem;
      case (op_q)
         OP_MUL:                        res_o = pfix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  res_o = pfix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               res_o = qfix;
         OP_REM, OP_REMU:               res_o = rfix;
         default:                       res_o = '0;
      endcase
   end

   assign done_o = busy_q && (cnt_q == '0);
   assign dbz_o  = dbz_q;

   // Load on start, iterate while the counter is nonzero, release on the correction edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         prod_q <= '0;
         opd_q  <= '0;
         op_q   <= OP_ADD;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= CNT_W'(XLEN);
         prod_q <= is_div(op_i) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
         opd_q  <= is_div(op_i) ? b_mag : a_mag;
         op_q   <= op_i;
         div_q  <= is_div(op_i);
         neg_q  <= a_neg ^ b_neg;
         rneg_q <= a_neg;
         dbz_q  <= is_div(op_i) && (b_i == '0);
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            prod_q <= div_q ? div_nxt : mul_nxt;
            cnt_q  <= cnt_q - CNT_W'(1);
         end else begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle RV32IM ALU: single-cycle base ops, iterative mul/div,
// valid/ready on both sides with a registered result.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  alu_op_e         op,
   input  logic [XLEN-1:0] term_a,
   input  logic [XLEN-1:0] term_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, base_res, core_res;
   logic            dbz_q, core_dbz, core_done;
   logic            start, ld_base, ld_iter;

   alu_iter_core #(.XLEN(XLEN), .SHW(SHW)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .op_i    (op),
      .a_i     (term_a),
      .b_i     (term_b),
      .done_o  (core_done),
      .res_o   (core_res),
      .dbz_o   (core_dbz)
   );

   // Single-cycle base operations; unused codes yield zero
   always_comb begin
      base_res = '0;
      case (op)
         OP_ADD:    base_res = term_a + term_b;
         OP_SUB:    base_res = term_a - term_b;
         OP_AND:    base_res = term_a & term_b;
         OP_OR:     base_res = term_a | term_b;
         OP_XOR:    base_res = term_a ^ term_b;
         OP_SLL:    base_res = term_a << term_b[SHW-1:0];
         OP_SRL:    base_res = term_a >> term_b[SHW-1:0];
         OP_SRA:    base_res = $unsigned($signed(term_a) >>> term_b[SHW-1:0]);
         OP_SLT:    base_res = {{(XLEN-1){1'b0}}, $signed(term_a) < $signed(term_b)};
         OP_SLTU:   base_res = {{(XLEN-1){1'b0}}, term_a < term_b};
         OP_PASS_B: base_res = term_b;
         default:   base_res = '0;
      endcase
   end

   // Handshake FSM: next state, handshake outputs and load strobes
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      start     = 1'b0;
      ld_base   = 1'b0;
      ld_iter   = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_mul(op)) begin
                  state_d = S_MUL;
                  start   = 1'b1;
               end else if (is_div(op)) begin
                  state_d = S_DIV;
                  start   = 1'b1;
               end else begin
                  state_d = S_DONE;
                  ld_base = 1'b1;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (core_done) begin
               state_d = S_DONE;
               ld_iter = 1'b1;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Output register; only written when a result is produced, so it holds under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else if (ld_base) begin
         result_q <= base_res;
         dbz_q    <= 1'b0;
      end else if (ld_iter) begin
         result_q <= core_res;
         dbz_q    <= core_dbz;
      end
   end

   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with hand-computed expectations.
module tb_alu_seq_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   alu_op_e     op = OP_ADD;
   logic [31:0] term_a = '0;
   logic [31:0] term_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        div_by_zero;

   int total = 0;
   int bad   = 0;

   alu_seq_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .term_a      (term_a),
      .term_b      (term_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Issue one op and wait (bounded) for out_valid; samples #1 after edges.
   task automatic run_op(input alu_op_e o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic d, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      op = o; term_a = a; term_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      term_a = 32'hDEAD_BEEF; term_b = 32'h1234_5678;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      r = result;
      d = div_by_zero;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({in_ready, out_valid, result, div_by_zero} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset: rdy=%b vld=%b res=%h dbz=%b want 1 0 0 0",
                  in_ready, out_valid, result, div_by_zero);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add_handshake();
      logic [31:0] r; logic d; int lat;
      run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, r, d, lat);
      total++;
      if (r !== 32'h8000_0000 || lat !== 1) begin
         bad++; $display("FAIL add: res=%h lat=%0d want 80000000 lat 1", r, lat);
      end
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL add_busy: in_ready=%b want 0", in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL add_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_base_ops();
      alu_op_e     ops [7];
      logic [31:0] as  [7];
      logic [31:0] bs  [7];
      logic [31:0] exp [7];
      logic [31:0] r; logic d; int lat;
      ops[0] = OP_SRA;          as[0] = 32'h8000_0000; bs[0] = 32'h24;         exp[0] = 32'hF800_0000;
      ops[1] = OP_SLTU;         as[1] = 32'h1;         bs[1] = 32'hFFFF_FFFF;  exp[1] = 32'h1;
      ops[2] = alu_op_e'(5'd25); as[2] = 32'h1234;     bs[2] = 32'h5678;       exp[2] = 32'h0;
      ops[3] = OP_SUB;          as[3] = 32'd5;         bs[3] = 32'd7;          exp[3] = 32'hFFFF_FFFE;
      ops[4] = OP_SLT;          as[4] = 32'hFFFF_FFFF; bs[4] = 32'h1;          exp[4] = 32'h1;
      ops[5] = OP_SLL;          as[5] = 32'h1;         bs[5] = 32'h3F;         exp[5] = 32'h8000_0000;
      ops[6] = OP_PASS_B;       as[6] = 32'h0;         bs[6] = 32'hCAFE_F00D;  exp[6] = 32'hCAFE_F00D;
      for (int i = 0; i < 7; i++) begin
         run_op(ops[i], as[i], bs[i], r, d, lat);
         total++;
         if (r !== exp[i] || d !== 1'b0 || lat !== 1) begin
            bad++;
            $display("FAIL base[%0d]: res=%h dbz=%b lat=%0d want %h 0 1", i, r, d, lat, exp[i]);
         end
      end
   endtask

   task automatic test_mul();
      alu_op_e     ops [4];
      logic [31:0] as  [4];
      logic [31:0] bs  [4];
      logic [31:0] exp [4];
      logic [31:0] r; logic d; int lat;
      ops[0] = OP_MULH;   as[0] = 32'hFFFF_FFFE; bs[0] = 32'd3;          exp[0] = 32'hFFFF_FFFF;
      ops[1] = OP_MUL;    as[1] = 32'hFFFF_FFFE; bs[1] = 32'd3;          exp[1] = 32'hFFFF_FFFA;
      ops[2] = OP_MULHU;  as[2] = 32'hFFFF_FFFF; bs[2] = 32'hFFFF_FFFF;  exp[2] = 32'hFFFF_FFFE;
      ops[3] = OP_MULHSU; as[3] = 32'hFFFF_FFFF; bs[3] = 32'hFFFF_FFFF;  exp[3] = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], r, d, lat);
         total++;
         if (r !== exp[i] || lat !== 34) begin
            bad++;
            $display("FAIL mul[%0d]: res=%h lat=%0d want %h lat 34", i, r, lat, exp[i]);
         end
      end
   endtask

   task automatic test_div();
      alu_op_e     ops [10];
      logic [31:0] as  [10];
      logic [31:0] bs  [10];
      logic [31:0] exp [10];
      logic        ed  [10];
      logic [31:0] r; logic d; int lat;
      ops[0] = OP_DIV;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;         exp[0] = 32'hFFFF_FFFD; ed[0] = 0;
      ops[1] = OP_REM;  as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;         exp[1] = 32'hFFFF_FFFF; ed[1] = 0;
      ops[2] = OP_DIVU; as[2] = 32'd7;         bs[2] = 32'd0;         exp[2] = 32'hFFFF_FFFF; ed[2] = 1;
      ops[3] = OP_REMU; as[3] = 32'd7;         bs[3] = 32'd0;         exp[3] = 32'd7;         ed[3] = 1;
      ops[4] = OP_DIV;  as[4] = 32'h8000_0000; bs[4] = 32'hFFFF_FFFF; exp[4] = 32'h8000_0000; ed[4] = 0;
      ops[5] = OP_REM;  as[5] = 32'h8000_0000; bs[5] = 32'hFFFF_FFFF; exp[5] = 32'h0;         ed[5] = 0;
      ops[6] = OP_DIV;  as[6] = 32'hFFFF_FFF9; bs[6] = 32'd0;         exp[6] = 32'hFFFF_FFFF; ed[6] = 1;
      ops[7] = OP_REM;  as[7] = 32'hFFFF_FFF9; bs[7] = 32'd0;         exp[7] = 32'hFFFF_FFF9; ed[7] = 1;
      ops[8] = OP_DIVU; as[8] = 32'd100;       bs[8] = 32'd7;         exp[8] = 32'd14;        ed[8] = 0;
      ops[9] = OP_REMU; as[9] = 32'd100;       bs[9] = 32'd7;         exp[9] = 32'd2;         ed[9] = 0;
      for (int i = 0; i < 10; i++) begin
         run_op(ops[i], as[i], bs[i], r, d, lat);
         total++;
         if (r !== exp[i] || d !== ed[i] || lat !== 34) begin
            bad++;
            $display("FAIL div[%0d]: res=%h dbz=%b lat=%0d want %h %b lat 34",
                     i, r, d, lat, exp[i], ed[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r; logic d; int lat;
      @(posedge clk); #1;
      out_ready = 1'b0;
      run_op(OP_DIVU, 32'd100, 32'd7, r, d, lat);
      total++;
      if (r !== 32'd14 || lat !== 34) begin
         bad++; $display("FAIL bp_first: res=%h lat=%0d want 0000000e lat 34", r, lat);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total++;
         if (result !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: res=%h vld=%b rdy=%b dbz=%b want 0000000e 1 0 0",
                     i, result, out_valid, in_ready, div_by_zero);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_mul();
      logic stale;
      logic [31:0] r; logic d; int lat;
      op = OP_MUL; term_a = 32'd1000; term_b = 32'd1000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         bad++;
         $display("FAIL rst_mid: vld=%b rdy=%b res=%h want 0 1 0", out_valid, in_ready, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
      end
      total++;
      if (stale !== 1'b0) begin
         bad++; $display("FAIL rst_stale: got a result after abandoned op, want none");
      end
      run_op(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, r, d, lat);
      total++;
      if (r !== 32'hF0F0_F0F0 || lat !== 1) begin
         bad++; $display("FAIL rst_recover: res=%h lat=%0d want f0f0f0f0 lat 1", r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_add_handshake();
      test_base_ops();
      test_mul();
      test_div();
      test_backpressure();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
